// File: rtl/mem_access_unit.sv
// mem_access_unit: parametrised MAR/MDR sequencer moving one word between the datapath and an on-chip data RAM
// Optional feature macro: MEM_ACCESS_AUTO_INC_EN (MAR post-increment on leaving DONE)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      access request, sampled in IDLE only
//   wr_rdn     1 = write, 0 = read, sampled with start
//   addr_hold  1 = reuse current MAR instead of addr_in
//   addr_in    access address
//   wr_data    write data, loaded into MDR when a write is accepted
//   mar_sclr   synchronous MAR clear, IDLE only, overrides load/hold
//   busy       high in ADDR, WAIT, XFER
//   done       one-cycle pulse in DONE or ERR
//   err        one-cycle pulse in ERR (address out of range)
//   rd_data    MDR contents
//   mar_m      MAR monitor
//   mdr_m      MDR monitor, identical to rd_data
module mem_access_unit #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  wr_rdn,
   input  logic                  addr_hold,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  mar_sclr,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] mar_m,
   output logic [DATA_WIDTH-1:0] mdr_m
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_XFER = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;
   localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] mar_q, mar_d;
   logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
   logic                  wr_q, wr_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] ram_rd_q;
   logic                  in_range;

   assign in_range = 32'(mar_q) < MEM_DEPTH;
   assign busy     = state_q == S_ADDR || state_q == S_WAIT || state_q == S_XFER;
   assign done     = state_q == S_DONE || state_q == S_ERR;
   assign err      = state_q == S_ERR;
   assign rd_data  = mdr_q;
   assign mdr_m    = mdr_q;
   assign mar_m    = mar_q;

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mar_d   = addr_hold ? mar_q : addr_in;
               mdr_d   = wr_rdn ? wr_data : mdr_q;
               wr_d    = wr_rdn;
               state_d = S_ADDR;
            end
            if (mar_sclr) mar_d = '0;
         end
         S_ADDR: begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = !in_range ? S_ERR : (WAIT_STATES == 0) ? S_XFER : S_WAIT;
         end
         S_WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? S_XFER : S_WAIT;
         end
         S_XFER: begin
            // ram_rd_q was registered from the stable MAR during ADDR/WAIT
            mdr_d   = wr_q ? mdr_q : ram_rd_q;
            state_d = S_DONE;
         end
         S_DONE: begin
`ifdef MEM_ACCESS_AUTO_INC_EN
            mar_d   = mar_q + 1'b1;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   // RAM is not reset; gating the write with rst keeps an aborted access from landing
   always_ff @(posedge clk) begin
      if (rst && state_q == S_XFER && wr_q) ram[mar_q[IW-1:0]] <= mdr_q;
      if (in_range) ram_rd_q <= ram[mar_q[IW-1:0]];
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit (two instances: WS=1/256 words, WS=0/128 words)
module tb_mem_access_unit;
   typedef struct {
      string      name;
      logic       err;
      logic [7:0] rd;
      logic [7:0] mar;
      int         busy;
      int         due;
   } exp_t;

`ifdef MEM_ACCESS_AUTO_INC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n [2];
   logic       start [2];
   logic       wr [2];
   logic       hold [2];
   logic       sclr [2];
   logic       busy [2];
   logic       done [2];
   logic       err [2];
   logic [7:0] addr [2];
   logic [7:0] wdat [2];
   logic [7:0] rd [2];
   logic [7:0] mar [2];
   logic [7:0] mdr [2];
   exp_t       q0[$];
   exp_t       q1[$];
   exp_t       me;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         bc [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(1)) u_a (
      .clk(clk), .rst(rst_n[0]), .start(start[0]), .wr_rdn(wr[0]), .addr_hold(hold[0]),
      .addr_in(addr[0]), .wr_data(wdat[0]), .mar_sclr(sclr[0]), .busy(busy[0]), .done(done[0]),
      .err(err[0]), .rd_data(rd[0]), .mar_m(mar[0]), .mdr_m(mdr[0]));

   mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(128), .WAIT_STATES(0)) u_b (
      .clk(clk), .rst(rst_n[1]), .start(start[1]), .wr_rdn(wr[1]), .addr_hold(hold[1]),
      .addr_in(addr[1]), .wr_data(wdat[1]), .mar_sclr(sclr[1]), .busy(busy[1]), .done(done[1]),
      .err(err[1]), .rd_data(rd[1]), .mar_m(mar[1]), .mdr_m(mdr[1]));

   function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d]) bc[d] = 0;
         else begin
            if (busy[d]) bc[d]++;
            if (done[d]) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done dut%0d: got done=1 expected no access", d);
               end else begin
                  if (d == 0) me = q0.pop_front();
                  else me = q1.pop_front();
                  chk({me.name, "_err"}, err[d], me.err);
                  chk({me.name, "_rd"}, rd[d], me.rd);
                  chk({me.name, "_mdr"}, mdr[d], me.rd);
                  chk({me.name, "_mar"}, mar[d], me.mar);
                  chk({me.name, "_lat"}, cyc, me.due);
                  chk({me.name, "_busy"}, bc[d], me.busy);
               end
               bc[d] = 0;
            end
         end
      end
   end

   task automatic acc(input int d, input string n, input logic w, h, s, input logic [7:0] a, wd,
                      input logic e_err, input logic [7:0] e_rd, e_mar, input int lat, bsy,
                      input logic dis);
      exp_t e;
      int   i;
      @(negedge clk);
      start[d] = 1'b1; wr[d] = w; hold[d] = h; sclr[d] = s; addr[d] = a; wdat[d] = wd;
      @(posedge clk);
      #1;
      e.name = n; e.err = e_err; e.rd = e_rd; e.mar = e_mar; e.busy = bsy; e.due = cyc + lat;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      start[d] = 1'b0; sclr[d] = 1'b0; hold[d] = 1'b0; addr[d] = ~a; wdat[d] = ~wd;
      if (dis) begin
         @(negedge clk);
         start[d] = 1'b1; wr[d] = ~w; sclr[d] = 1'b1; addr[d] = 8'h99; wdat[d] = 8'hEE;
         @(negedge clk);
         start[d] = 1'b0; sclr[d] = 1'b0;
      end
      for (i = 0; i < 50 && !done[d]; i++) @(negedge clk);
      chk({n, "_done_seen"}, done[d], 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; start[d] = 1'b0; wr[d] = 1'b0; hold[d] = 1'b0; sclr[d] = 1'b0;
         addr[d] = 8'h00; wdat[d] = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", busy[d], 1'b0);
         chk("rst_done", done[d], 1'b0);
         chk("rst_err", err[d], 1'b0);
         chk("rst_rd", rd[d], 8'h00);
         chk("rst_mar", mar[d], 8'h00);
      end
      // WAIT_STATES=1: done 3 edges after the accept edge, busy 3 cycles
      acc(0, "w10",   1, 0, 0, 8'h10, 8'hA5, 0, 8'hA5, 8'h10, 3, 3, 0);
      acc(0, "r10",   0, 0, 0, 8'h10, 8'h00, 0, 8'hA5, 8'h10, 3, 3, 0);
      acc(0, "w00",   1, 0, 0, 8'h00, 8'h5A, 0, 8'h5A, 8'h00, 3, 3, 0);
      acc(0, "wFE",   1, 0, 0, 8'hFE, 8'h11, 0, 8'h11, 8'hFE, 3, 3, 0);
      acc(0, "whold", 1, 1, 0, 8'h33, 8'h22, 0, 8'h22, AI ? 8'hFF : 8'hFE, 3, 3, 0);
      acc(0, "rhold", 0, 1, 0, 8'h44, 8'h00, 0, AI ? 8'h5A : 8'h22, AI ? 8'h00 : 8'hFE, 3, 3, 0);
      acc(0, "rFE",   0, 0, 0, 8'hFE, 8'h00, 0, AI ? 8'h11 : 8'h22, 8'hFE, 3, 3, 0);
      acc(0, "w20dis", 1, 0, 0, 8'h20, 8'h77, 0, 8'h77, 8'h20, 3, 3, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_queued_start", busy[0], 1'b0);
      end
      chk("mar_after_dis", mar[0], AI ? 8'h21 : 8'h20);
      acc(0, "r20",   0, 0, 0, 8'h20, 8'h00, 0, 8'h77, 8'h20, 3, 3, 0);
      @(negedge clk);
      sclr[0] = 1'b1;
      @(negedge clk);
      sclr[0] = 1'b0;
      chk("sclr_mar", mar[0], 8'h00);
      chk("sclr_idle", busy[0], 1'b0);
      acc(0, "w05",   1, 0, 0, 8'h05, 8'h66, 0, 8'h66, 8'h05, 3, 3, 0);
      // abort a write of 0x3C to 0x05 while in WAIT
      @(negedge clk);
      start[0] = 1'b1; wr[0] = 1'b1; hold[0] = 1'b0; addr[0] = 8'h05; wdat[0] = 8'h3C;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy[0], 1'b1);
      chk("pre_rst_mdr", rd[0], 8'h3C);
      rst_n[0] = 1'b0;
      #1;
      chk("mid_rst_busy", busy[0], 1'b0);
      chk("mid_rst_done", done[0], 1'b0);
      chk("mid_rst_err", err[0], 1'b0);
      chk("mid_rst_rd", rd[0], 8'h00);
      chk("mid_rst_mar", mar[0], 8'h00);
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      acc(0, "r05_old", 0, 0, 0, 8'h05, 8'h00, 0, 8'h66, 8'h05, 3, 3, 0);
      // WAIT_STATES=0, MEM_DEPTH=128: normal done 2 edges after accept, error 1 edge
      acc(1, "sclr_w", 1, 0, 1, 8'h40, 8'h5C, 0, 8'h5C, 8'h00, 2, 2, 0);
      acc(1, "r00",    0, 0, 0, 8'h00, 8'h00, 0, 8'h5C, 8'h00, 2, 2, 0);
      acc(1, "rFF",    0, 0, 0, 8'hFF, 8'h00, 1, 8'h5C, 8'hFF, 1, 1, 0);
      acc(1, "rhold_err", 0, 1, 0, 8'h00, 8'h00, 1, 8'h5C, 8'hFF, 1, 1, 0);
      acc(1, "r80",    0, 0, 0, 8'h80, 8'h00, 1, 8'h5C, 8'h80, 1, 1, 0);
      acc(1, "r00_again", 0, 0, 0, 8'h00, 8'h00, 0, 8'h5C, 8'h00, 2, 2, 0);
      repeat (3) @(negedge clk);
      chk("queues_empty", q0.size() + q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
